// File: rtl/player_ship_ctrl_if.sv
// player_ship_ctrl_if
//   Bundles the keyboard, restart, enemy-box and ship-state signals of the
//   player ship controller.
//   slave  : controller side (takes keys/enemies, drives ship state)
//   master : environment side (drives keys/enemies, observes ship state)
//   Signals:
//     keycode      N_KEYS 8-bit keycode slots, slot k = keycode[8k+7:8k]
//     restart      leaves GAME_OVER when sampled high
//     enemy_x/y    enemy box top-left corner, one entry per enemy
//     enemy_size   enemy box side length
//     enemy_alive  per-enemy collision enable
//     ship_x/y     ship centre
//     ship_w/h     current half-width / half-height
//     left_move    ship moving left this frame
//     right_move   ship moving right this frame
//     hit_pulse    one-frame pulse per counted hit
//     hit_mask     enemies overlapping the ship when the last hit was counted
//     lives        remaining lives
//     invuln       respawn invulnerability active
//     game_over    game over state
interface player_ship_ctrl_if #(
    parameter int unsigned N_ENEMY = 4,
    parameter int unsigned N_KEYS  = 3
);
    logic [8*N_KEYS-1:0] keycode;
    logic                restart;
    logic [9:0]          enemy_x    [N_ENEMY];
    logic [9:0]          enemy_y    [N_ENEMY];
    logic [9:0]          enemy_size [N_ENEMY];
    logic [N_ENEMY-1:0]  enemy_alive;

    logic [9:0]          ship_x;
    logic [9:0]          ship_y;
    logic [9:0]          ship_w;
    logic [9:0]          ship_h;
    logic                left_move;
    logic                right_move;
    logic                hit_pulse;
    logic [N_ENEMY-1:0]  hit_mask;
    logic [2:0]          lives;
    logic                invuln;
    logic                game_over;

    modport slave (
        input  keycode, restart, enemy_x, enemy_y, enemy_size, enemy_alive,
        output ship_x, ship_y, ship_w, ship_h, left_move, right_move,
               hit_pulse, hit_mask, lives, invuln, game_over
    );

    modport master (
        output keycode, restart, enemy_x, enemy_y, enemy_size, enemy_alive,
        input  ship_x, ship_y, ship_w, ship_h, left_move, right_move,
               hit_pulse, hit_mask, lives, invuln, game_over
    );
endinterface

// File: rtl/player_ship_ctrl.sv
// player_ship_ctrl
//   Player spaceship controller for the meteorite-dodge game. Moves the ship
//   from keyboard keycodes, clamps it to the play field, checks collision
//   against N_ENEMY enemy boxes and runs the lives / hit / respawn
//   invulnerability / game-over state machine.
//   Ports:
//     frame_clk  frame clock, one rising edge per video frame
//     Reset      asynchronous, active-high
//     bus        player_ship_ctrl_if.slave (keys, restart, enemies in;
//                ship position/size, movement flags, hit info, lives,
//                invuln and game_over out)
module player_ship_ctrl #(
    parameter int unsigned N_ENEMY    = 4,
    parameter int unsigned N_KEYS     = 3,
    parameter int unsigned X_MIN      = 9,
    parameter int unsigned X_MAX      = 630,
    parameter int unsigned Y_MIN      = 6,
    parameter int unsigned Y_MAX      = 473,
    parameter int unsigned SPAWN_X    = 320,
    parameter int unsigned SPAWN_Y    = 450,
    parameter int unsigned SPEED      = 3,
    parameter int unsigned HALF_W     = 17,
    parameter int unsigned HALF_W_MV  = 14,
    parameter int unsigned HALF_H     = 16,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned HIT_FRAMES = 30,
    parameter int unsigned INV_FRAMES = 120
) (
    input logic               frame_clk,
    input logic               Reset,
    player_ship_ctrl_if.slave bus
);

    localparam int unsigned T_MAX = (HIT_FRAMES > INV_FRAMES) ? HIT_FRAMES : INV_FRAMES;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic signed [10:0] X_LO  = 11'(X_MIN + HALF_W);
    localparam logic signed [10:0] X_HI  = 11'(X_MAX - HALF_W);
    localparam logic signed [10:0] Y_LO  = 11'(Y_MIN + HALF_H);
    localparam logic signed [10:0] Y_HI  = 11'(Y_MAX - HALF_H);
    localparam logic signed [10:0] STEP  = 11'(SPEED);
    localparam logic [9:0]         SPX   = 10'(SPAWN_X);
    localparam logic [9:0]         SPY   = 10'(SPAWN_Y);
    localparam logic [2:0]         LV0   = 3'(LIVES);
    localparam logic [TW-1:0]      T_HIT = TW'(HIT_FRAMES - 1);
    localparam logic [TW-1:0]      T_INV = TW'(INV_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_ALIVE,
        ST_HIT,
        ST_INVULN,
        ST_GAME_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               lm_q, lm_d, rm_q, rm_d;
    logic [2:0]         lives_q, lives_d;
    logic               hp_q, hp_d;
    logic [N_ENEMY-1:0] mask_q, mask_d;

    logic               key_a, key_d, key_s, key_w;
    logic               go_left, go_right;
    logic signed [10:0] nx, ny;
    logic [9:0]         w;
    logic [10:0]        sx_lo, sx_hi, sy_lo, sy_hi;
    logic [N_ENEMY-1:0] hits;

    // Key decode: a key counts if it appears in any slot.
    always_comb begin
        key_a = 1'b0;
        key_d = 1'b0;
        key_s = 1'b0;
        key_w = 1'b0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            if (bus.keycode[8*k +: 8] == 8'h04) key_a = 1'b1;
            if (bus.keycode[8*k +: 8] == 8'h07) key_d = 1'b1;
            if (bus.keycode[8*k +: 8] == 8'h16) key_s = 1'b1;
            if (bus.keycode[8*k +: 8] == 8'h1A) key_w = 1'b1;
        end
    end

    // Candidate position for a frame with movement enabled (left/down win).
    always_comb begin
        go_left  = key_a;
        go_right = key_d & ~key_a;
        nx = signed'({1'b0, x_q});
        ny = signed'({1'b0, y_q});
        if (go_left)       nx = nx - STEP;
        else if (go_right) nx = nx + STEP;
        if (key_s)         ny = ny + STEP;
        else if (key_w)    ny = ny - STEP;
        if (nx < X_LO)      nx = X_LO;
        else if (nx > X_HI) nx = X_HI;
        if (ny < Y_LO)      ny = Y_LO;
        else if (ny > Y_HI) ny = Y_HI;
    end

    assign w = (lm_q | rm_q) ? 10'(HALF_W_MV) : 10'(HALF_W);

    // Ship box edges in 11 bits so x-w and ex+es never wrap.
    assign sx_lo = {1'b0, x_q} - {1'b0, w};
    assign sx_hi = {1'b0, x_q} + {1'b0, w};
    assign sy_lo = {1'b0, y_q} - 11'(HALF_H);
    assign sy_hi = {1'b0, y_q} + 11'(HALF_H);

    always_comb begin
        hits = '0;
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            hits[i] = bus.enemy_alive[i]
                && (sx_lo <= ({1'b0, bus.enemy_x[i]} + {1'b0, bus.enemy_size[i]}))
                && (sy_lo <= ({1'b0, bus.enemy_y[i]} + {1'b0, bus.enemy_size[i]}))
                && (sx_hi >  {1'b0, bus.enemy_x[i]})
                && (sy_hi >  {1'b0, bus.enemy_y[i]});
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_ALIVE;
            timer_q <= '0;
            x_q     <= SPX;
            y_q     <= SPY;
            lm_q    <= 1'b0;
            rm_q    <= 1'b0;
            lives_q <= LV0;
            hp_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lm_q    <= lm_d;
            rm_q    <= rm_d;
            lives_q <= lives_d;
            hp_q    <= hp_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        x_d     = x_q;
        y_d     = y_q;
        lm_d    = 1'b0;
        rm_d    = 1'b0;
        lives_d = lives_q;
        hp_d    = 1'b0;
        mask_d  = mask_q;
        unique case (state_q)
            ST_ALIVE: begin
                x_d  = nx[9:0];
                y_d  = ny[9:0];
                lm_d = go_left;
                rm_d = go_right;
                // Any number of simultaneous hits costs exactly one life.
                if (|hits) begin
                    lives_d = lives_q - 3'd1;
                    hp_d    = 1'b1;
                    mask_d  = hits;
                    if (lives_q <= 3'd1) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                        timer_d = '0;
                    end else begin
                        state_d = ST_HIT;
                        timer_d = T_HIT;
                    end
                end
            end
            ST_HIT: begin
                if (timer_q == '0) begin
                    x_d     = SPX;
                    y_d     = SPY;
                    state_d = ST_INVULN;
                    timer_d = T_INV;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_INVULN: begin
                x_d  = nx[9:0];
                y_d  = ny[9:0];
                lm_d = go_left;
                rm_d = go_right;
                if (timer_q == '0) state_d = ST_ALIVE;
                else               timer_d = timer_q - 1'b1;
            end
            ST_GAME_OVER: begin
                if (bus.restart) begin
                    state_d = ST_ALIVE;
                    lives_d = LV0;
                    x_d     = SPX;
                    y_d     = SPY;
                    mask_d  = '0;
                end
            end
            default: state_d = ST_ALIVE;
        endcase
    end

    assign bus.ship_x     = x_q;
    assign bus.ship_y     = y_q;
    assign bus.ship_w     = w;
    assign bus.ship_h     = 10'(HALF_H);
    assign bus.left_move  = lm_q;
    assign bus.right_move = rm_q;
    assign bus.hit_pulse  = hp_q;
    assign bus.hit_mask   = mask_q;
    assign bus.lives      = lives_q;
    assign bus.invuln     = (state_q == ST_INVULN);
    assign bus.game_over  = (state_q == ST_GAME_OVER);

endmodule
